// File: rtl/controller_serial_reader_if.sv
// Pad-side and register-side signals of the joypad serial front end.
// master: the reader (drives latch/pulse, presents buttons).
// slave:  the controller pad plus the downstream joypad register block.
interface controller_serial_reader_if;
    logic       I_DATA;
    logic       O_LATCH;
    logic       O_PULSE;
    logic [7:0] O_BUTTONS;
    logic       O_VALID;

    modport master (
        input  I_DATA,
        output O_LATCH,
        output O_PULSE,
        output O_BUTTONS,
        output O_VALID
    );

    modport slave (
        output I_DATA,
        input  O_LATCH,
        input  O_PULSE,
        input  O_BUTTONS,
        input  O_VALID
    );
endinterface

// File: rtl/controller_serial_reader.sv
// controller_serial_reader: scans an NES-style shift-register pad
// (latch / pulse / data) every POLL_CYCLES clocks and presents the eight
// buttons as an active-high vector (bit 7 START .. bit 0 RIGHT).
// Optional macro CONTROLLER_DEBOUNCE_EN: O_BUTTONS only updates when two
// consecutive scans agree.
module controller_serial_reader #(
    parameter int LATCH_CYCLES = 396,
    parameter int HALF_CYCLES  = 198,
    parameter int POLL_CYCLES  = 33333
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET_L,
    controller_serial_reader_if.master  bus
);
    localparam int TMAX   = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int TIM_W  = $clog2(TMAX + 1);
    localparam int POLL_W = $clog2(POLL_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LATCH, GAP, PHI, PLO, DONE} state_t;

    state_t             state_q, state_d;
    logic [TIM_W-1:0]   timer_q, timer_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic [2:0]         bit_q, bit_d;
    logic               sync1_q, sync2_q;
    logic [7:0]         sr_q, sr_d;
    logic [7:0]         buttons_q, buttons_d;
    logic               latch_q, latch_d;
    logic               pulse_q, pulse_d;
    logic               valid_q, valid_d;
    logic               timer_done, poll_expired, sample_en;
    logic [7:0]         scan;
`ifdef CONTROLLER_DEBOUNCE_EN
    logic [7:0]         raw_q, raw_d;
`endif

    assign timer_done   = (timer_q == '0);
    assign poll_expired = (poll_q == '0);
    assign sample_en    = timer_done && ((state_q == GAP) || (state_q == PLO));

    // State register plus all datapath flops; reset returns every flop to its idle value
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            poll_q    <= '0;
            bit_q     <= '0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sr_q      <= '0;
            buttons_q <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
`ifdef CONTROLLER_DEBOUNCE_EN
            raw_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            poll_q    <= poll_d;
            bit_q     <= bit_d;
            sync1_q   <= bus.I_DATA;
            sync2_q   <= sync1_q;
            sr_q      <= sr_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            valid_q   <= valid_d;
`ifdef CONTROLLER_DEBOUNCE_EN
            raw_q     <= raw_d;
`endif
        end
    end

    // Next-state logic; DONE chains straight into LATCH when the poll period is already over
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (poll_expired) state_d = LATCH;
            LATCH: if (timer_done)   state_d = GAP;
            GAP:   if (timer_done)   state_d = PHI;
            PHI:   if (timer_done)   state_d = PLO;
            PLO:   if (timer_done)   state_d = (bit_q == 3'd7) ? DONE : PHI;
            DONE:  state_d = poll_expired ? LATCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase timer, poll counter and bit index; all reload on state entry and never wrap
    always_comb begin
        timer_d = timer_q;
        poll_d  = poll_q;
        bit_d   = bit_q;
        if (state_d != state_q) begin
            case (state_d)
                LATCH:       timer_d = TIM_W'(LATCH_CYCLES - 1);
                GAP, PHI, PLO: timer_d = TIM_W'(HALF_CYCLES - 1);
                default:     timer_d = '0;
            endcase
        end else if (!timer_done) begin
            timer_d = timer_q - 1'b1;
        end
        if ((state_d == LATCH) && (state_q != LATCH)) begin
            poll_d = POLL_W'(POLL_CYCLES - 1);
        end else if (!poll_expired) begin
            poll_d = poll_q - 1'b1;
        end
        if ((state_d == LATCH) && (state_q != LATCH)) begin
            bit_d = '0;
        end else if (sample_en && (bit_q != 3'd7)) begin
            bit_d = bit_q + 1'b1;
        end
    end

    // Capture the inverted synchronized bit in wire order, remap to button order, update outputs
    always_comb begin
        sr_d = sr_q;
        if (sample_en) begin
            sr_d[bit_q] = ~sync2_q;
        end
        // wire order A,B,SELECT,START,UP,DOWN,LEFT,RIGHT -> bits 4,5,6,7,2,3,1,0
        scan = {sr_d[3], sr_d[2], sr_d[1], sr_d[0], sr_d[5], sr_d[4], sr_d[6], sr_d[7]};

        buttons_d = buttons_q;
`ifdef CONTROLLER_DEBOUNCE_EN
        raw_d = raw_q;
        if (state_d == DONE) begin
            raw_d = scan;
            if (scan == raw_q) begin
                buttons_d = scan;
            end
        end
`else
        if (state_d == DONE) begin
            buttons_d = scan;
        end
`endif
        latch_d = (state_d == LATCH);
        pulse_d = (state_d == PHI);
        valid_d = (state_d == DONE);
    end

    assign bus.O_LATCH   = latch_q;
    assign bus.O_PULSE   = pulse_q;
    assign bus.O_VALID   = valid_q;
    assign bus.O_BUTTONS = buttons_q;
endmodule

// File: tb/tb_controller_serial_reader.sv
// Directed bench for controller_serial_reader with a behavioural pad model.
module tb_controller_serial_reader;
    logic clk  = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    controller_serial_reader_if bus();
    controller_serial_reader_if bus40();

    controller_serial_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(3), .POLL_CYCLES(64)) u_dut (
        .I_CLK(clk), .I_RESET_L(rst_l), .bus(bus));
    controller_serial_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(3), .POLL_CYCLES(40)) u_dut40 (
        .I_CLK(clk), .I_RESET_L(rst_l), .bus(bus40));

    int checks = 0;
    int errors = 0;

    // Pad model: button-order press vector, shifted out in wire order
    logic [7:0] press = 8'h00;
    int   idx = 8;
    logic pulse_prev = 1'b0;

    function automatic logic wire_bit(input int i, input logic [7:0] p);
        case (i)
            0: return ~p[4];
            1: return ~p[5];
            2: return ~p[6];
            3: return ~p[7];
            4: return ~p[2];
            5: return ~p[3];
            6: return ~p[1];
            7: return ~p[0];
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.O_LATCH) idx <= 0;
        else if (bus.O_PULSE && !pulse_prev && idx < 8) idx <= idx + 1;
        pulse_prev <= bus.O_PULSE;
    end
    assign bus.I_DATA   = wire_bit(idx, press);
    assign bus40.I_DATA = 1'b1;

    // Bounded wait for the next O_VALID of the 64-cycle instance
    task automatic wait_valid(output logic [7:0] got);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.O_VALID && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.O_VALID) begin
            errors++;
            $display("FAIL wait_valid timeout: O_VALID not seen, required within 200 cycles");
        end
        got = bus.O_BUTTONS;
    endtask

    // Synchronise to a scan boundary, change the pad, return the next full scan
    task automatic do_scan(input logic [7:0] p, output logic [7:0] got);
        logic [7:0] dummy;
        wait_valid(dummy);
        press = p;
        wait_valid(got);
    endtask

    task automatic scan_check(input logic [7:0] p, input string name);
        logic [7:0] got;
        do_scan(p, got);
`ifndef CONTROLLER_DEBOUNCE_EN
        checks++;
        if (got !== p) begin
            errors++;
            $display("FAIL %s first scan: got %h required %h", name, got, p);
        end
`endif
        wait_valid(got);
        checks++;
        if (got !== p) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, p);
        end
        $display("scan %s: buttons %h", name, got);
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.O_LATCH !== 1'b0) begin errors++; $display("FAIL reset latch: got %b required 0", bus.O_LATCH); end
        checks++; if (bus.O_PULSE !== 1'b0) begin errors++; $display("FAIL reset pulse: got %b required 0", bus.O_PULSE); end
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL reset valid: got %b required 0", bus.O_VALID); end
        checks++; if (bus.O_BUTTONS !== 8'h00) begin errors++; $display("FAIL reset buttons: got %h required 00", bus.O_BUTTONS); end
        $display("reset: latch %b pulse %b valid %b buttons %h", bus.O_LATCH, bus.O_PULSE, bus.O_VALID, bus.O_BUTTONS);
    endtask

    task automatic test_first_scan();
        logic [2:0] exp, got;
        press = 8'h00;
        rst_l = 1'b1;
        for (int c = 0; c <= 64; c++) begin
            @(negedge clk);
            exp[2] = (c < 4) || (c == 64);
            exp[1] = (c >= 7) && (c < 49) && (((c - 7) % 6) < 3);
            exp[0] = (c == 49);
            got = {bus.O_LATCH, bus.O_PULSE, bus.O_VALID};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL first_scan cycle %0d latch/pulse/valid: got %b required %b", c, got, exp);
            end
            if (c == 49) begin
                checks++;
                if (bus.O_BUTTONS !== 8'h00) begin
                    errors++;
                    $display("FAIL first_scan buttons: got %h required 00", bus.O_BUTTONS);
                end
                $display("first scan: valid at cycle 49 buttons %h", bus.O_BUTTONS);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] exp_btn;
`ifdef CONTROLLER_DEBOUNCE_EN
        exp_btn = 8'h00;
`else
        exp_btn = 8'hFF;
`endif
        n = 0;
        @(negedge clk);
        while (!bus.O_LATCH && n < 200) begin @(negedge clk); n++; end
        if (!bus.O_LATCH) begin errors++; $display("FAIL reset_mid: latch not seen, required within 200 cycles"); end
        repeat (25) @(negedge clk);
        checks++;
        if (bus.O_PULSE !== 1'b1) begin errors++; $display("FAIL reset_mid pulse4 phase: got %b required 1", bus.O_PULSE); end
        rst_l = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.O_LATCH, bus.O_PULSE, bus.O_VALID, bus.O_BUTTONS} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %b%b%b %h required 000 00", bus.O_LATCH, bus.O_PULSE, bus.O_VALID, bus.O_BUTTONS);
        end
        @(negedge clk);
        rst_l = 1'b1;
        for (int c = 0; c <= 49; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                checks++;
                if (bus.O_LATCH !== (c < 4)) begin
                    errors++;
                    $display("FAIL reset_mid latch cycle %0d: got %b required %b", c, bus.O_LATCH, (c < 4));
                end
            end
        end
        checks++;
        if (bus.O_VALID !== 1'b1 || bus.O_BUTTONS !== exp_btn) begin
            errors++;
            $display("FAIL reset_mid rescan: valid %b buttons %h required 1 %h", bus.O_VALID, bus.O_BUTTONS, exp_btn);
        end
        $display("reset mid-scan: rescan valid %b buttons %h", bus.O_VALID, bus.O_BUTTONS);
    endtask

    task automatic test_poll_short();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus40.O_VALID && n < 200) begin @(negedge clk); n++; end
        if (!bus40.O_VALID) begin errors++; $display("FAIL poll_short: valid not seen, required within 200 cycles"); end
        @(negedge clk);
        checks++;
        if (bus40.O_LATCH !== 1'b1) begin errors++; $display("FAIL poll_short latch after valid: got %b required 1", bus40.O_LATCH); end
        n = 1;
        while (!bus40.O_VALID && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n != 50) begin errors++; $display("FAIL poll_short period: got %0d required 50", n); end
        $display("poll short: period %0d", n);
    endtask

    task automatic test_debounce();
        logic [7:0] got;
        logic [7:0] p [5];
        logic [7:0] e [5];
        p = '{8'h00, 8'h20, 8'h00, 8'h20, 8'h20};
`ifdef CONTROLLER_DEBOUNCE_EN
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
`else
        e = '{8'h00, 8'h20, 8'h00, 8'h20, 8'h20};
`endif
        do_scan(p[0], got);
        checks++;
        if (got !== e[0]) begin errors++; $display("FAIL debounce step 0: got %h required %h", got, e[0]); end
        $display("debounce step 0: pad %h buttons %h", p[0], got);
        for (int i = 1; i < 5; i++) begin
            press = p[i];
            wait_valid(got);
            checks++;
            if (got !== e[i]) begin errors++; $display("FAIL debounce step %0d: got %h required %h", i, got, e[i]); end
            $display("debounce step %0d: pad %h buttons %h", i, p[i], got);
        end
    endtask

    initial begin
        test_reset();
        test_first_scan();
        scan_check(8'h10, "A");
        scan_check(8'h01, "RIGHT");
        scan_check(8'h88, "START_DOWN");
        scan_check(8'hFF, "ALL");
        test_reset_mid();
        test_poll_short();
        test_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/controller_serial_reader.md
# controller_serial_reader

Serial front end for the GBC joypad path. Drives the NES-style shift-register controller (latch/pulse/data), periodically scans all eight buttons, and presents them as a parallel, active-high button vector to the P1 joypad register block. Sits directly upstream of the joypad register block, whose `buttons_pressed` bus it feeds using the `START..RIGHT` bit indices.

## Interface
- `LATCH_CYCLES`, default 396: O_LATCH high width in clocks (12 µs @ 33 MHz).
- `HALF_CYCLES`, default 198: width of each pulse-high and pulse-low phase, and of the post-latch gap (6 µs). Legal values are ≥ 3.
- `POLL_CYCLES`, default 33333: clocks from one latch rising edge to the next (1 ms).

- `I_CLK`, in, 1: sole clock (33 MHz controller clock).
- `I_RESET_L`, in, 1: synchronous, active-low reset.
- `I_DATA`, in, 1: controller serial data, active-low (0 = pressed), asynchronous to I_CLK.
- `O_LATCH`, out, 1: controller latch, active-high.
- `O_PULSE`, out, 1: controller shift clock, active-high.
- `O_BUTTONS`, out, 8: button state, 1 = pressed; bit 7 START, 6 SELECT, 5 B, 4 A, 3 DOWN, 2 UP, 1 LEFT, 0 RIGHT.
- `O_VALID`, out, 1: one-cycle strobe marking each completed scan.

## Operation
- I_DATA passes through a 2-flop synchronizer. All sampling uses the synchronized bit. Each sampled bit is inverted before storage.
- The FSM states are IDLE, LATCH, GAP, PHI, PLO and DONE.
  - IDLE: O_LATCH and O_PULSE are 0. Moves to LATCH when the poll counter expires. The first scan starts on the first edge with I_RESET_L high.
  - LATCH: O_LATCH is 1 for LATCH_CYCLES clocks, then moves to GAP.
  - GAP: both outputs are 0 for HALF_CYCLES clocks. Bit 0 (A) is sampled on the last GAP cycle. Moves to PHI.
  - PHI: O_PULSE is 1 for HALF_CYCLES clocks, then moves to PLO.
  - PLO: O_PULSE is 0 for HALF_CYCLES clocks, and the next bit is sampled on the last PLO cycle. The bit counter runs 1..7, and the state returns to PHI until bit 7 is taken, then moves to DONE.
  - DONE: one cycle. Loads O_BUTTONS from the shift register and pulses O_VALID. Moves to IDLE.
- The wire order is A, B, SELECT, START, UP, DOWN, LEFT, RIGHT. These map to O_BUTTONS bits 4, 5, 6, 7, 2, 3, 1, 0.
- The poll counter reloads on every entry to LATCH. If POLL_CYCLES is shorter than the scan length, the next scan begins on the cycle after DONE, with no IDLE cycles.
- The counters are wide enough for `POLL_CYCLES` and wrap on reload only. No arithmetic overflow is permitted.

## Timing
- Reset values:
  - O_LATCH = 0, O_PULSE = 0, O_VALID = 0, O_BUTTONS = 8'h00.
  - Shift register = 0, synchronizer flops = 1 (released), FSM = IDLE, poll counter = expired.
- Reset asserted mid-scan forces all of the reset values on the next edge. O_BUTTONS is cleared; there is no partial update.
- Scan length, from O_LATCH rising to O_VALID high, is LATCH_CYCLES + 15·HALF_CYCLES clocks.
  - O_VALID is high in exactly that cycle.
  - O_BUTTONS changes in the same cycle as O_VALID and holds until the next DONE.
- O_LATCH and O_PULSE are never high together. Both come directly from flops, with no glitches.
- Effective sample point is the pad value 2 clocks before the sampling edge. The pad must be stable for ≥ 3 clocks before each sample; `HALF_CYCLES` ≥ 3 guarantees this.

## Configuration
- `CONTROLLER_DEBOUNCE_EN` defined:
  - A raw-scan register holds the previous scan (reset 0).
  - In DONE, O_BUTTONS loads only if the new scan equals the previous raw scan; the raw register always updates.
  - O_VALID still pulses every DONE.
- Undefined: O_BUTTONS loads on every DONE, and the raw register is absent.

## Test plan
Test parameters: LATCH_CYCLES = 4, HALF_CYCLES = 3, POLL_CYCLES = 64.
- Reset release with I_DATA held 1: O_LATCH is high for cycles 0–3, then 7 pulses of 3 high / 3 low. O_VALID is high at cycle 49 with O_BUTTONS = 8'h00. The next latch rises at cycle 64.
- Model drives only A pressed (0 during GAP and before pulse 1) -> O_BUTTONS = 8'h10. Only RIGHT pressed (0 after pulse 7) -> 8'h01.
- Model presses START and DOWN -> O_BUTTONS = 8'h88. All eight pressed -> 8'hFF.
- Reset asserted during the pulse 4 high phase: on the next edge all outputs are 0 and O_BUTTONS = 8'h00. A fresh scan starts after release, with a full latch width.
- POLL_CYCLES = 40 (below the scan length of 49): the latch rises on the cycle after each O_VALID, and the period is 50 clocks.
- With CONTROLLER_DEBOUNCE_EN, a single scan showing 8'h20 between 8'h00 scans keeps O_BUTTONS = 8'h00. Two consecutive 8'h20 scans set it to 8'h20 on the second O_VALID.
